// File: rtl/exec_stage_pkg.sv
// Shared encodings and EX/MEM word layout for the execute stage.
// Field offsets are relative to M*N (control block) or 2*M*N (upper control).
package exec_stage_pkg;

  typedef enum logic [3:0] {
    ALU_ZERO = 4'b0000,
    ALU_ADD  = 4'b0001,
    ALU_SUB  = 4'b0010,
    ALU_MUL  = 4'b0011,
    ALU_CMP  = 4'b0100,
    ALU_AND  = 4'b0101,
    ALU_OR   = 4'b0110,
    ALU_XOR  = 4'b0111,
    ALU_PASS = 4'b1000,
    ALU_VADD = 4'b1101,
    ALU_VSUB = 4'b1110,
    ALU_VMUL = 4'b1111
  } alu_op_e;

  typedef enum logic [1:0] {
    OPTYPE_ALU    = 2'b00,
    OPTYPE_MEM    = 2'b01,
    OPTYPE_BRANCH = 2'b10,
    OPTYPE_OTHER  = 2'b11
  } op_type_e;

  localparam int unsigned OFS_RC        = 0;
  localparam int unsigned OFS_REGWRITE  = 4;
  localparam int unsigned OFS_MEMTOREG  = 5;
  localparam int unsigned OFS_MEMWRITE  = 6;
  localparam int unsigned OFS_BRANCH    = 7;
  localparam int unsigned OFS_NEG       = 8;
  localparam int unsigned OFS_ZERO      = 9;
  localparam int unsigned OFS_RESULT    = 10;

  localparam int unsigned OFS_OPCODE    = 10;
  localparam int unsigned OFS_OPTYPE    = 14;
  localparam int unsigned OFS_MODESEL   = 16;
  localparam int unsigned OFS_REGWRITEV = 17;

  localparam int unsigned BUF_EXTRA_BITS = 18;

  function automatic int unsigned buf_width(input int unsigned n, input int unsigned m);
    return 2 * m * n + BUF_EXTRA_BITS;
  endfunction

endpackage

// File: rtl/exec_stage_lane_alu.sv
// One N-bit lane of the execute ALU; scalar and vector codes share the datapath
// since lanes never carry into each other.
module exec_lane_alu
  import exec_stage_pkg::*;
#(
  parameter int N = 24
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic [3:0]   i_ctrl,
  output logic [N-1:0] o_y
);

  always_comb begin
    o_y = '0;
    case (i_ctrl)
      ALU_ADD,  ALU_VADD: o_y = i_a + i_b;
      ALU_SUB,  ALU_CMP,
      ALU_VSUB:           o_y = i_a - i_b;
      ALU_MUL,  ALU_VMUL: o_y = i_a * i_b;
      ALU_AND:            o_y = i_a & i_b;
      ALU_OR:             o_y = i_a | i_b;
      ALU_XOR:            o_y = i_a ^ i_b;
      ALU_PASS:           o_y = i_a;
      default:            o_y = '0;
    endcase
  end

endmodule

// File: rtl/exec_stage.sv
// Execute stage: operand selection, M lane ALUs, compare flags and the
// registered EX/MEM word.
module exec_stage
  import exec_stage_pkg::*;
#(
  parameter int N  = 24,
  parameter int M  = 6,
  parameter int BW = 2*M*N+18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N-1:0]     rd1,
  input  logic [N-1:0]     rd2,
  input  logic [N-1:0]     rd3,
  input  logic [N-1:0]     pc,
  input  logic [N-1:0]     imm,
  input  logic [M*N-1:0]   rdv1,
  input  logic [M*N-1:0]   rdv2,
  input  logic [M*N-1:0]   rdv3,
  input  logic [M*N-1:0]   Forward1,
  input  logic [M*N-1:0]   Forward2,
  input  logic [M*N-1:0]   Forward3,
  input  logic             Fa,
  input  logic             Fb,
  input  logic             Fc,
  input  logic [3:0]       aluControl,
  input  logic [3:0]       Rc,
  input  logic             immSrc,
  input  logic             branchFlag,
  input  logic             memWrite,
  input  logic             memToReg,
  input  logic             regWrite,
  input  logic             regWriteV,
  input  logic             modeSel,
  input  logic [1:0]       opType,
  input  logic [3:0]       opCode,
  output logic [BW-1:0]    bufferOut
);

  localparam logic [M*N-1:0] LANE0_MASK = {{(M-1)*N{1'b0}}, {N{1'b1}}};

  if (BW != buf_width(N, M)) begin : g_bw_check
    $error("exec_stage: BW must equal 2*M*N+18");
  end

  logic [M*N-1:0] w_op_a;
  logic [M*N-1:0] w_op_b;
  logic [M*N-1:0] w_store;
  logic [M*N-1:0] w_alu_raw;
  logic [M*N-1:0] w_result;
  logic           w_cmp;
  logic           w_neg;
  logic           w_zero;
  logic [BW-1:0]  w_next;
  logic [BW-1:0]  r_buf;

  // Scalar sources land in lane 0; branches use the PC as operand A.
  always_comb begin
    w_op_a = '0;
    if (Fa)                          w_op_a = Forward1;
    else if (modeSel)                w_op_a = rdv1;
    else if (opType == OPTYPE_BRANCH) w_op_a[N-1:0] = pc;
    else                             w_op_a[N-1:0] = rd1;
  end

  always_comb begin
    w_op_b = '0;
    if (immSrc)       w_op_b[N-1:0] = imm;
    else if (Fb)      w_op_b = Forward2;
    else if (modeSel) w_op_b = rdv2;
    else              w_op_b[N-1:0] = rd2;
  end

  always_comb begin
    w_store = '0;
    if (Fc)           w_store = Forward3;
    else if (modeSel) w_store = rdv3;
    else              w_store[N-1:0] = rd3;
    if (!modeSel)     w_store = w_store & LANE0_MASK;
  end

  for (genvar g = 0; g < M; g++) begin : g_lane
    exec_lane_alu #(.N(N)) u_lane_alu (
      .i_a    (w_op_a[g*N +: N]),
      .i_b    (w_op_b[g*N +: N]),
      .i_ctrl (aluControl),
      .o_y    (w_alu_raw[g*N +: N])
    );
  end

  assign w_result = modeSel ? w_alu_raw : (w_alu_raw & LANE0_MASK);

  // Flags are only meaningful for a scalar compare.
  assign w_cmp  = !modeSel && (aluControl == ALU_CMP);
  assign w_neg  = w_cmp && w_result[N-1];
  assign w_zero = w_cmp && (w_result[N-1:0] == '0);

  always_comb begin
    w_next = '0;
    w_next[0 +: M*N]                    = w_store;
    w_next[M*N + OFS_RC +: 4]           = Rc;
    w_next[M*N + OFS_REGWRITE]          = regWrite;
    w_next[M*N + OFS_MEMTOREG]          = memToReg;
    w_next[M*N + OFS_MEMWRITE]          = memWrite;
    w_next[M*N + OFS_BRANCH]            = branchFlag;
    w_next[M*N + OFS_NEG]               = w_neg;
    w_next[M*N + OFS_ZERO]              = w_zero;
    w_next[M*N + OFS_RESULT +: M*N]     = w_result;
    w_next[2*M*N + OFS_OPCODE +: 4]     = opCode;
    w_next[2*M*N + OFS_OPTYPE +: 2]     = opType;
    w_next[2*M*N + OFS_MODESEL]         = modeSel;
    w_next[2*M*N + OFS_REGWRITEV]       = regWriteV;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    r_buf <= '0;
    else if (en) r_buf <= w_next;
  end

  assign bufferOut = r_buf;

endmodule

// File: tb/tb_exec_stage.sv
// Directed and randomized checks of exec_stage against a lane-array reference model.
module tb_exec_stage;
  localparam int N  = 24;
  localparam int M  = 6;
  localparam int BW = 306;

  logic            clk = 1'b0;
  logic            rst, en;
  logic [N-1:0]    rd1, rd2, rd3, pc, imm;
  logic [M*N-1:0]  rdv1, rdv2, rdv3, Forward1, Forward2, Forward3;
  logic            Fa, Fb, Fc, immSrc, branchFlag, memWrite, memToReg, regWrite, regWriteV, modeSel;
  logic [3:0]      aluControl, Rc, opCode;
  logic [1:0]      opType;
  logic [BW-1:0]   bufferOut;

  int compared   = 0;
  int mismatched = 0;
  logic [BW-1:0] exp_word;

  exec_stage #(.N(N), .M(M), .BW(BW)) dut (
    .clk(clk), .rst(rst), .en(en),
    .rd1(rd1), .rd2(rd2), .rd3(rd3), .pc(pc), .imm(imm),
    .rdv1(rdv1), .rdv2(rdv2), .rdv3(rdv3),
    .Forward1(Forward1), .Forward2(Forward2), .Forward3(Forward3),
    .Fa(Fa), .Fb(Fb), .Fc(Fc),
    .aluControl(aluControl), .Rc(Rc), .immSrc(immSrc),
    .branchFlag(branchFlag), .memWrite(memWrite), .memToReg(memToReg),
    .regWrite(regWrite), .regWriteV(regWriteV),
    .modeSel(modeSel), .opType(opType), .opCode(opCode),
    .bufferOut(bufferOut)
  );

  always #5 clk = ~clk;

  function automatic logic [BW-1:0] model();
    logic [BW-1:0] w;
    longint        a, b, r, r0;
    longint        modv;
    logic [N-1:0]  s;
    modv = longint'(1) << N;
    w  = '0;
    r0 = 0;
    for (int i = 0; i < M; i++) begin
      if (Fa)                 a = longint'(Forward1[i*N +: N]);
      else if (modeSel)       a = longint'(rdv1[i*N +: N]);
      else if (i != 0)        a = 0;
      else if (opType == 2'b10) a = longint'(pc);
      else                    a = longint'(rd1);

      if (immSrc)             b = (i == 0) ? longint'(imm) : 0;
      else if (Fb)            b = longint'(Forward2[i*N +: N]);
      else if (modeSel)       b = longint'(rdv2[i*N +: N]);
      else                    b = (i == 0) ? longint'(rd2) : 0;

      if (Fc)                 s = Forward3[i*N +: N];
      else if (modeSel)       s = rdv3[i*N +: N];
      else                    s = (i == 0) ? rd3 : '0;

      case (aluControl)
        4'd1, 4'd13:        r = (a + b) % modv;
        4'd2, 4'd4, 4'd14:  r = (a - b + modv) % modv;
        4'd3, 4'd15:        r = (a * b) % modv;
        4'd5:               r = a & b;
        4'd6:               r = a | b;
        4'd7:               r = a ^ b;
        4'd8:               r = a;
        default:            r = 0;
      endcase
      if (!modeSel && i > 0) begin
        r = 0;
        s = '0;
      end
      if (i == 0) r0 = r;
      w[i*N +: N]       = s;
      w[154 + i*N +: N] = N'(r);
    end
    w[147:144] = Rc;
    w[148] = regWrite;
    w[149] = memToReg;
    w[150] = memWrite;
    w[151] = branchFlag;
    w[152] = (!modeSel && aluControl == 4'd4) && (r0 >= (longint'(1) << (N-1)));
    w[153] = (!modeSel && aluControl == 4'd4) && (r0 == 0);
    w[301:298] = opCode;
    w[303:302] = opType;
    w[304] = modeSel;
    w[305] = regWriteV;
    return w;
  endfunction

  task automatic chk(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] want);
    compared++;
    assert (got === want) else begin
      mismatched++;
      $error("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic clear_inputs();
    rd1 = '0; rd2 = '0; rd3 = '0; pc = '0; imm = '0;
    rdv1 = '0; rdv2 = '0; rdv3 = '0;
    Forward1 = '0; Forward2 = '0; Forward3 = '0;
    Fa = 0; Fb = 0; Fc = 0; immSrc = 0;
    branchFlag = 0; memWrite = 0; memToReg = 0; regWrite = 0; regWriteV = 0;
    modeSel = 0; opType = '0; opCode = '0; aluControl = '0; Rc = '0;
  endtask

  task automatic step();
    logic [BW-1:0] nxt;
    logic          e;
    nxt = model();
    e   = en;
    @(posedge clk);
    if (e) exp_word = nxt;
    #1;
  endtask

  task automatic randomize_inputs();
    rd1 = N'($urandom); rd2 = N'($urandom); rd3 = N'($urandom);
    pc  = N'($urandom); imm = N'($urandom);
    for (int i = 0; i < M; i++) begin
      rdv1[i*N +: N]     = N'($urandom);
      rdv2[i*N +: N]     = N'($urandom);
      rdv3[i*N +: N]     = N'($urandom);
      Forward1[i*N +: N] = N'($urandom);
      Forward2[i*N +: N] = N'($urandom);
      Forward3[i*N +: N] = N'($urandom);
    end
    if ($urandom_range(0, 3) == 0) rd2 = rd1;
    Fa = 1'($urandom); Fb = 1'($urandom); Fc = 1'($urandom);
    immSrc = ($urandom_range(0, 3) == 0);
    branchFlag = 1'($urandom); memWrite = 1'($urandom); memToReg = 1'($urandom);
    regWrite = 1'($urandom); regWriteV = 1'($urandom); modeSel = 1'($urandom);
    opType = 2'($urandom); opCode = 4'($urandom); Rc = 4'($urandom);
    aluControl = 4'($urandom);
    en = ($urandom_range(0, 4) != 0);
  endtask

  initial begin
    logic [BW-1:0] held;
    clear_inputs();
    en  = 0;
    rst = 1;
    exp_word = '0;

    #2 rst = 0;
    #1 chk("async_reset", bufferOut, '0);
    rst = 1;
    en  = 1;
    step();
    chk("zero_inputs", bufferOut, '0);

    // scalar add: not visible before the capturing edge
    rd1 = 24'd1; rd2 = 24'd2; aluControl = 4'b0001;
    #1 chk("add_before_edge", bufferOut, '0);
    step();
    chk("scalar_add_word", bufferOut, exp_word);
    chk("scalar_add_result", BW'(bufferOut[177:154]), BW'(24'd3));
    chk("scalar_add_flags", BW'({bufferOut[153:152], bufferOut[304]}), '0);

    // pass-through control bits
    clear_inputs();
    Rc = 4'd15; regWrite = 1; memToReg = 1; memWrite = 1; regWriteV = 1;
    modeSel = 1; opCode = 4'd7; opType = 2'b10;
    step();
    chk("passthru_word", bufferOut, exp_word);
    chk("passthru_fields",
        BW'({bufferOut[305:298], bufferOut[150:144]}),
        BW'({1'b1, 1'b1, 2'd2, 4'd7, 3'b111, 4'd15}));

    // vector add
    clear_inputs();
    modeSel = 1; aluControl = 4'b1101;
    for (int i = 0; i < M; i++) begin
      rdv1[i*N +: N] = N'(i + 1);
      rdv2[i*N +: N] = N'(i + 7);
    end
    step();
    chk("vadd_word", bufferOut, exp_word);
    for (int i = 0; i < M; i++)
      chk($sformatf("vadd_lane%0d", i), BW'(bufferOut[154 + i*N +: N]), BW'(8 + 2*i));
    chk("vadd_flags", BW'(bufferOut[153:152]), '0);

    // compare, negative
    clear_inputs();
    aluControl = 4'b0100; rd1 = 24'd1; rd2 = 24'd4;
    step();
    chk("cmp_neg_word", bufferOut, exp_word);
    chk("cmp_neg_result", BW'(bufferOut[177:154]), BW'(24'hFFFFFD));
    chk("cmp_neg_flags", BW'(bufferOut[153:152]), BW'(2'b01));

    // compare, equal
    rd2 = 24'd1;
    step();
    chk("cmp_eq_result", BW'(bufferOut[177:154]), '0);
    chk("cmp_eq_flags", BW'(bufferOut[153:152]), BW'(2'b10));

    // stall holds
    held = bufferOut;
    en = 0; rd1 = 24'd77; aluControl = 4'b0001; Rc = 4'd9;
    step();
    chk("stall_hold", bufferOut, held);

    // forwarding with vector add
    clear_inputs();
    en = 1; modeSel = 1; aluControl = 4'b1101; Fa = 1; Fb = 1;
    for (int i = 0; i < M; i++) begin
      Forward1[i*N +: N] = N'(25 + i);
      Forward2[i*N +: N] = N'(19 + 3*i);
      rdv1[i*N +: N]     = N'(1000 + i);
      rdv2[i*N +: N]     = N'(2000 + i);
    end
    step();
    chk("fwd_word", bufferOut, exp_word);
    chk("fwd_lane0", BW'(bufferOut[177:154]), BW'(24'd44));

    // reset released during a stall stays zero until the first enabled edge
    #2 rst = 0;
    #1 chk("midrun_reset", bufferOut, '0);
    en = 0;
    rst = 1;
    exp_word = '0;
    step();
    chk("reset_then_stall", bufferOut, '0);
    en = 1;
    step();
    chk("first_enabled_edge", bufferOut, exp_word);

    for (int k = 0; k < 300; k++) begin
      randomize_inputs();
      step();
      chk($sformatf("rand_%0d", k), bufferOut, exp_word);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
